// File: rtl/controlador_venda.sv
// controlador_venda: vending machine sequencer.
// Collects a two-key product code, accumulates coin credit in 25c units,
// dispenses when the credit covers the price and returns change one pulse per unit.
// Optional stock check: define MAQ_ESTOQUE_EN to add estoque_vazio/erro_estoque.
module controlador_venda #(
  parameter int CREDITO_W      = 5,
  parameter int PRECO_W        = 5,
  parameter int TIMEOUT_CICLOS = 50000000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [3:0]           tecla,
  input  logic                 cent25,
  input  logic                 cent50,
  input  logic                 real1,
  input  logic                 cancela,
  input  logic [PRECO_W-1:0]   preco,
`ifdef MAQ_ESTOQUE_EN
  input  logic                 estoque_vazio,
  output logic                 erro_estoque,
`endif
  output logic [3:0]           codigoProduto,
  output logic                 codigo_valido,
  output logic [CREDITO_W-1:0] credito,
  output logic                 libera,
  output logic                 troco_pulso,
  output logic                 rejeita_moeda,
  output logic                 ocupado
);

  localparam int LW = (CREDITO_W > PRECO_W) ? CREDITO_W : PRECO_W;
  localparam int TW = $clog2(TIMEOUT_CICLOS) + 1;

  typedef enum logic [2:0] {OCIOSO, DIGITO2, PAGAMENTO, LIBERA, TROCO} estado_t;

  estado_t              estado, prox;
  logic [3:0]           tecla_q;
  logic                 cent25_q, cent50_q, real1_q, cancela_q;
  logic [3:0]           tecla_sub;
  logic                 tecla_ok;
  logic [1:0]           tecla_cod;
  logic [2:0]           moedas;
  logic                 cancela_sub;
  logic [CREDITO_W:0]   soma;
  logic                 estouro;
  logic [CREDITO_W-1:0] base;
  logic [LW-1:0]        base_l, preco_l;
  logic                 atividade, timeout;
  logic [TW-1:0]        cnt;
  logic                 troco_alto, alto_prox;
  logic [PRECO_W-1:0]   preco_q, preco_prox;
  logic [CREDITO_W-1:0] cred_prox;
  logic [3:0]           cod_prox;
  logic                 val_prox;
`ifdef MAQ_ESTOQUE_EN
  logic                 erro_prox;
`endif

  assign tecla_sub   = tecla & ~tecla_q;
  assign tecla_ok    = $onehot(tecla_sub);
  // Coin weights 1/2/4 line up with bit positions, so the edge vector is the sum.
  assign moedas      = {real1 & ~real1_q, cent50 & ~cent50_q, cent25 & ~cent25_q};
  assign cancela_sub = cancela & ~cancela_q;
  assign soma        = {1'b0, credito} + (CREDITO_W+1)'(moedas);
  assign estouro     = soma[CREDITO_W];
  assign base        = estouro ? credito : soma[CREDITO_W-1:0];
  assign base_l      = LW'(base);
  assign preco_l     = LW'(preco);
  assign atividade   = (|tecla_sub) | (|moedas);
  assign timeout     = ((estado == DIGITO2) || (estado == PAGAMENTO)) &&
                       (cnt == TW'(TIMEOUT_CICLOS - 1)) && !atividade;

  assign libera      = (estado == LIBERA);
  assign troco_pulso = (estado == TROCO) && troco_alto;
  assign ocupado     = (estado != OCIOSO);

  // Encode the single pressed key as its index.
  always_comb begin
    tecla_cod = '0;
    for (int unsigned i = 0; i < 4; i++)
      if (tecla_sub[i]) tecla_cod = 2'(i);
  end

  // Next state and next datapath values; credit always includes this cycle's accepted coins.
  always_comb begin
    prox       = estado;
    cred_prox  = base;
    cod_prox   = codigoProduto;
    val_prox   = codigo_valido;
    preco_prox = preco_q;
    alto_prox  = troco_alto;
`ifdef MAQ_ESTOQUE_EN
    erro_prox  = 1'b0;
`endif
    case (estado)
      OCIOSO: begin
        if (tecla_ok) begin
          cod_prox[3:2] = tecla_cod;
          prox          = DIGITO2;
        end else if (cancela_sub && (base != '0)) begin
          prox = TROCO;
        end
      end
      DIGITO2: begin
        if (tecla_ok) begin
          cod_prox[1:0] = tecla_cod;
          val_prox      = 1'b1;
          prox          = PAGAMENTO;
        end else if (cancela_sub || timeout) begin
          cod_prox = '0;
          val_prox = 1'b0;
          prox     = (base != '0) ? TROCO : OCIOSO;
        end
      end
      PAGAMENTO: begin
`ifdef MAQ_ESTOQUE_EN
        if (estoque_vazio) begin
          erro_prox = 1'b1;
          cod_prox  = '0;
          val_prox  = 1'b0;
          prox      = (base != '0) ? TROCO : OCIOSO;
        end else
`endif
        if (base_l >= preco_l) begin
          preco_prox = preco;
          prox       = LIBERA;
        end else if (cancela_sub || timeout) begin
          cod_prox = '0;
          val_prox = 1'b0;
          prox     = (base != '0) ? TROCO : OCIOSO;
        end
      end
      LIBERA: begin
        cred_prox = CREDITO_W'(base_l - LW'(preco_q));
        val_prox  = 1'b0;
        prox      = (cred_prox != '0) ? TROCO : OCIOSO;
      end
      TROCO: begin
        if (troco_alto) begin
          cred_prox = base - CREDITO_W'(1);
          alto_prox = 1'b0;
        end else begin
          alto_prox = 1'b1;
          if (base == '0) prox = OCIOSO;
        end
      end
      default: prox = OCIOSO;
    endcase
    if ((prox == TROCO) && (estado != TROCO)) alto_prox = 1'b1;
  end

  // State, edge history, credit and code registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado        <= OCIOSO;
      tecla_q       <= '0;
      cent25_q      <= 1'b0;
      cent50_q      <= 1'b0;
      real1_q       <= 1'b0;
      cancela_q     <= 1'b0;
      credito       <= '0;
      codigoProduto <= '0;
      codigo_valido <= 1'b0;
      rejeita_moeda <= 1'b0;
      preco_q       <= '0;
      troco_alto    <= 1'b0;
    end else begin
      estado        <= prox;
      tecla_q       <= tecla;
      cent25_q      <= cent25;
      cent50_q      <= cent50;
      real1_q       <= real1;
      cancela_q     <= cancela;
      credito       <= cred_prox;
      codigoProduto <= cod_prox;
      codigo_valido <= val_prox;
      rejeita_moeda <= estouro;
      preco_q       <= preco_prox;
      troco_alto    <= alto_prox;
    end
  end

  // Inactivity counter for the code-entry and payment states.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt <= '0;
    else if ((prox != estado) || atividade)
      cnt <= '0;
    else if ((estado == DIGITO2) || (estado == PAGAMENTO))
      cnt <= cnt + TW'(1);
  end

`ifdef MAQ_ESTOQUE_EN
  // Out-of-stock pulse, registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) erro_estoque <= 1'b0;
    else          erro_estoque <= erro_prox;
  end
`endif

endmodule

// File: tb/tb_controlador_venda.sv
// Bench for controlador_venda: directed scenarios plus random stimulus,
// checked by a scoreboard fed from a behavioural model of the vending rules.
module tb_controlador_venda;
  localparam int CW   = 5;
  localparam int PW   = 5;
  localparam int TO   = 12;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [3:0]    tecla = '0;
  logic          cent25 = 1'b0, cent50 = 1'b0, real1 = 1'b0, cancela = 1'b0;
  logic [PW-1:0] preco = '0;
  logic [3:0]    codigoProduto;
  logic          codigo_valido;
  logic [CW-1:0] credito;
  logic          libera, troco_pulso, rejeita_moeda, ocupado;

  controlador_venda #(.CREDITO_W(CW), .PRECO_W(PW), .TIMEOUT_CICLOS(TO)) dut (
    .clk(clk), .reset_n(reset_n), .tecla(tecla), .cent25(cent25), .cent50(cent50),
    .real1(real1), .cancela(cancela), .preco(preco), .codigoProduto(codigoProduto),
    .codigo_valido(codigo_valido), .credito(credito), .libera(libera),
    .troco_pulso(troco_pulso), .rejeita_moeda(rejeita_moeda), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nome, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nome, got, exp, $time);
    end
  endtask

  // Scoreboard queues
  typedef struct { int ciclo; int cred; bit ocup; bit codv; logic [3:0] cod; } st_t;
  typedef struct { int ciclo; bit lib; bit tro; bit rej; } ev_t;
  st_t stq[$];
  ev_t evq[$];
  bit  sb_ativo = 1'b0;

  // Reference model: machine mode, credit, code and edge history
  typedef enum {M_IDLE, M_CODE2, M_PAY, M_DISP, M_CHANGE} modo_t;
  modo_t      m_st;
  int         m_cred, m_cnt, m_preco_q, ncyc;
  logic [3:0] m_cod, m_pt;
  bit         m_codv, m_hi, m_rej, m_p25, m_p50, m_p1, m_pc;
  int         tabela[16];
  int         n_troco, n_lib, n_rej;

  task automatic model_reset();
    m_st = M_IDLE; m_cred = 0; m_cnt = 0; m_preco_q = 0;
    m_cod = '0; m_pt = '0; m_codv = 0; m_hi = 0; m_rej = 0;
    m_p25 = 0; m_p50 = 0; m_p1 = 0; m_pc = 0;
  endtask

  task automatic model_step(input logic [3:0] t, input bit c25, input bit c50,
                            input bit r1, input bit canc, input int pr);
    logic [3:0] rise;
    int nk, key, coins, sum, base;
    bit can, act, tmo;
    modo_t nst;
    st_t s;
    ev_t e;
    s.ciclo = ncyc; s.cred = m_cred; s.ocup = (m_st != M_IDLE); s.codv = m_codv; s.cod = m_cod;
    stq.push_back(s);
    e.ciclo = ncyc; e.lib = (m_st == M_DISP); e.tro = (m_st == M_CHANGE) && m_hi; e.rej = m_rej;
    if (e.lib || e.tro || e.rej) evq.push_back(e);
    rise = t & ~m_pt;
    nk = $countones(rise);
    key = 0;
    for (int i = 0; i < 4; i++) if (rise[i]) key = i;
    coins = ((c25 && !m_p25) ? 1 : 0) + ((c50 && !m_p50) ? 2 : 0) + ((r1 && !m_p1) ? 4 : 0);
    can = canc && !m_pc;
    sum = m_cred + coins;
    m_rej = (sum > CMAX);
    base = m_rej ? m_cred : sum;
    act = (rise != 0) || (coins != 0);
    tmo = ((m_st == M_CODE2) || (m_st == M_PAY)) && (m_cnt == TO - 1) && !act;
    nst = m_st;
    case (m_st)
      M_IDLE:
        if (nk == 1) begin m_cod[3:2] = key[1:0]; nst = M_CODE2; end
        else if (can && base > 0) nst = M_CHANGE;
      M_CODE2:
        if (nk == 1) begin m_cod[1:0] = key[1:0]; m_codv = 1; nst = M_PAY; end
        else if (can || tmo) begin m_cod = '0; m_codv = 0; nst = (base > 0) ? M_CHANGE : M_IDLE; end
      M_PAY:
        if (base >= pr) begin m_preco_q = pr; nst = M_DISP; end
        else if (can || tmo) begin m_cod = '0; m_codv = 0; nst = (base > 0) ? M_CHANGE : M_IDLE; end
      M_DISP: begin
        base = base - m_preco_q; m_codv = 0; nst = (base > 0) ? M_CHANGE : M_IDLE;
      end
      M_CHANGE:
        if (m_hi) begin base = base - 1; m_hi = 0; end
        else begin m_hi = 1; if (base == 0) nst = M_IDLE; end
      default: nst = M_IDLE;
    endcase
    if (nst == M_CHANGE && m_st != M_CHANGE) m_hi = 1;
    if (nst != m_st || act) m_cnt = 0;
    else if (m_st == M_CODE2 || m_st == M_PAY) m_cnt++;
    m_cred = base; m_st = nst;
    m_pt = t; m_p25 = c25; m_p50 = c50; m_p1 = r1; m_pc = canc;
    ncyc++;
  endtask

  task automatic ciclo(input logic [3:0] t, input bit c25, input bit c50, input bit r1, input bit canc);
    @(posedge clk); #1;
    if (troco_pulso) n_troco++;
    if (libera) n_lib++;
    if (rejeita_moeda) n_rej++;
    tecla = t; cent25 = c25; cent50 = c50; real1 = r1; cancela = canc;
    preco = PW'(tabela[m_cod]);
    sb_ativo = 1'b1;
    model_step(t, c25, c50, r1, canc, tabela[m_cod]);
  endtask

  task automatic idle(input int n);
    repeat (n) ciclo(4'b0000, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    sb_ativo = 1'b0;
    stq.delete(); evq.delete();
    reset_n = 1'b0;
    tecla = '0; cent25 = 0; cent50 = 0; real1 = 0; cancela = 0; preco = '0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    model_reset();
  endtask

  // Monitor: pops the expected status every cycle and an expected event whenever the DUT pulses
  initial begin
    st_t s;
    ev_t e;
    forever begin
      @(negedge clk);
      if (reset_n && sb_ativo && stq.size() > 0) begin
        s = stq.pop_front();
        chk("credito", int'(credito), s.cred);
        chk("ocupado", int'(ocupado), int'(s.ocup));
        chk("codigo_valido", int'(codigo_valido), int'(s.codv));
        if (s.codv) chk("codigoProduto", int'(codigoProduto), int'(s.cod));
        while (evq.size() > 0 && evq[0].ciclo < s.ciclo) begin
          e = evq.pop_front();
          checks++; errors++;
          $display("FAIL evento_ausente: cycle %0d got no pulse, required lib=%0d tro=%0d rej=%0d",
                   e.ciclo, e.lib, e.tro, e.rej);
        end
        if (libera || troco_pulso || rejeita_moeda) begin
          if (evq.size() > 0 && evq[0].ciclo == s.ciclo) begin
            e = evq.pop_front();
            chk("libera", int'(libera), int'(e.lib));
            chk("troco_pulso", int'(troco_pulso), int'(e.tro));
            chk("rejeita_moeda", int'(rejeita_moeda), int'(e.rej));
          end else begin
            checks++; errors++;
            $display("FAIL evento_inesperado: cycle %0d got lib=%0d tro=%0d rej=%0d, required none",
                     s.ciclo, libera, troco_pulso, rejeita_moeda);
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] t;
    ncyc = 0; n_troco = 0; n_lib = 0; n_rej = 0;
    model_reset();
    for (int i = 0; i < 16; i++) tabela[i] = $urandom_range(1, 12);
    tabela[3] = 6; tabela[4] = 3; tabela[15] = 31;

    // Reset state
    do_reset();
    #1;
    chk("rst_credito", int'(credito), 0);
    chk("rst_ocupado", int'(ocupado), 0);
    chk("rst_codigo_valido", int'(codigo_valido), 0);

    // Code entry 0,3 then exact payment of 6 (4 + 2)
    ciclo(4'b0001, 0, 0, 0, 0); idle(1);
    ciclo(4'b1000, 0, 0, 0, 0); idle(1);
    chk("codigo_0011", int'(codigoProduto), 3);
    chk("codigo_valido_set", int'(codigo_valido), 1);
    chk("ocupado_set", int'(ocupado), 1);
    ciclo(4'b0000, 0, 0, 1, 0); idle(1);
    chk("credito_4", int'(credito), 4);
    n_lib = 0; n_troco = 0;
    ciclo(4'b0000, 0, 1, 0, 0); idle(1);
    chk("libera_latencia", int'(libera), 1);
    idle(4);
    chk("libera_uma_vez", n_lib, 1);
    chk("credito_zero_exato", int'(credito), 0);
    chk("sem_troco", n_troco, 0);

    // Price 3 with 8 credit: one dispense, five change pulses
    do_reset();
    ciclo(4'b0010, 0, 0, 0, 0); idle(1);
    ciclo(4'b0000, 0, 0, 1, 0); idle(1);
    ciclo(4'b0000, 0, 0, 1, 0); idle(1);
    chk("credito_8", int'(credito), 8);
    n_lib = 0; n_troco = 0;
    ciclo(4'b0001, 0, 0, 0, 0); idle(20);
    chk("troco_lib", n_lib, 1);
    chk("troco_5", n_troco, 5);
    chk("troco_credito_0", int'(credito), 0);
    chk("troco_ocioso", int'(ocupado), 0);

    // Simultaneous keys ignored; cancel in DIGITO2 returns credit
    do_reset();
    ciclo(4'b0110, 0, 0, 0, 0); idle(1);
    chk("duas_teclas", int'(ocupado), 0);
    ciclo(4'b0000, 0, 1, 0, 0); idle(1);
    ciclo(4'b0001, 0, 0, 0, 0); idle(1);
    n_troco = 0;
    ciclo(4'b0000, 0, 0, 0, 1); idle(8);
    chk("cancela_troco", n_troco, 2);
    chk("cancela_codv", int'(codigo_valido), 0);
    chk("cancela_ocioso", int'(ocupado), 0);

    // Overflow rejection at 30, then timeout in PAGAMENTO
    do_reset();
    repeat (7) begin ciclo(4'b0000, 0, 0, 1, 0); idle(1); end
    ciclo(4'b0000, 0, 1, 0, 0); idle(1);
    n_rej = 0;
    ciclo(4'b0000, 0, 0, 1, 0); idle(2);
    chk("rejeita_pulso", n_rej, 1);
    chk("credito_30", int'(credito), 30);
    ciclo(4'b1000, 0, 0, 0, 0); idle(1);
    ciclo(4'b1000, 0, 0, 0, 0);
    n_troco = 0;
    idle(80);
    chk("timeout_troco", n_troco, 30);
    chk("timeout_ocioso", int'(ocupado), 0);

    // Reset in the middle of TROCO with credit 3
    do_reset();
    ciclo(4'b0000, 1, 1, 0, 0); idle(1);
    ciclo(4'b0000, 0, 0, 0, 1); idle(1);
    #1;
    chk("pre_rst_troco", int'(troco_pulso), 1);
    chk("pre_rst_credito", int'(credito), 3);
    sb_ativo = 1'b0;
    stq.delete(); evq.delete();
    reset_n = 1'b0;
    #1;
    chk("rst_async_troco", int'(troco_pulso), 0);
    chk("rst_async_credito", int'(credito), 0);
    chk("rst_async_ocupado", int'(ocupado), 0);
    chk("rst_async_libera", int'(libera), 0);
    chk("rst_async_codigo", int'(codigoProduto), 0);
    @(posedge clk); #3 reset_n = 1'b1;
    model_reset();
    n_troco = 0;
    idle(6);
    chk("rst_sem_troco", n_troco, 0);

    // Random stimulus
    do_reset();
    repeat (3000) begin
      if ($urandom_range(0, 99) < 3) idle(TO + 2);
      else begin
        int pk;
        pk = $urandom_range(0, 9);
        t = '0;
        if (pk < 2) t[$urandom_range(0, 3)] = 1'b1;
        else if (pk == 2) t = 4'($urandom_range(0, 15));
        ciclo(t, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 7) == 0, $urandom_range(0, 24) == 0);
      end
    end
    idle(3);
    @(negedge clk); #1;
    chk("eventos_pendentes", evq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
